uart_frame_loader: RTL and testbench

Byte-stream frame decoder directly downstream of the UART receiver on the Basys3 wrapper. It consumes received bytes, parses framed load/run commands from the host, and assembles little-endian words. It drives a single-cycle memory write port into CPU program memory and a CPU hold/run control, verifying every frame with an 8-bit checksum.

---
 rtl/uart_frame_loader.sv | 153 +++++++++++++++
 tb/tb_uart_frame_loader.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/uart_frame_loader.sv
// uart_frame_loader: decodes SYNC/CMD/payload/CHK byte frames into memory writes and CPU hold/run control.
module uart_frame_loader #(
  parameter int         WORD_BYTES     = 2,
  parameter int         ADDR_W         = 16,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 1_000_000,
  parameter bit         HOLD_AT_RESET  = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [7:0]              in_data,
  input  logic                    in_valid,
  output logic                    wr_en,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic [8*WORD_BYTES-1:0] wr_data,
  output logic                    cpu_hold,
  output logic                    run_pulse,
  output logic                    frame_done,
  output logic                    frame_error,
  output logic                    busy
);
  localparam int DW = 8*WORD_BYTES;
  localparam int BW = WORD_BYTES > 1 ? $clog2(WORD_BYTES) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ALO, S_AHI, S_LEN, S_PAY, S_CHK} state_t;
  state_t            state_q, state_d;
  logic [7:0]        sum_q, sum_d, lo_q, lo_d, words_q, words_d;
  logic [ADDR_W-1:0] addr_q, addr_d, wr_addr_q, wr_addr_d;
  logic [BW-1:0]     byte_q, byte_d;
  logic [DW-1:0]     buf_q, buf_d, wr_data_q, wr_data_d, buf_sh;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              is_run_q, is_run_d, wr_en_q, wr_en_d, hold_q, hold_d;
  logic              run_pulse_q, run_pulse_d, done_q, done_d, err_q, err_d, busy_q, busy_d;
  logic [7:0]        chk_sum;
  logic              last_byte, good, timeout;
  assign chk_sum   = sum_q + in_data;
  assign good      = chk_sum == 8'd0;
  assign last_byte = byte_q == BW'(WORD_BYTES-1);
  // first byte ends up in the low lane once WORD_BYTES bytes have been shifted in
  assign buf_sh    = (buf_q >> 8) | (DW'(in_data) << (DW-8));
  assign timeout   = state_q != S_IDLE && !in_valid && (tmo_q + 1'b1) == TW'(TIMEOUT_CYCLES-1);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      sum_q       <= '0;
      lo_q        <= '0;
      words_q     <= '0;
      addr_q      <= '0;
      byte_q      <= '0;
      buf_q       <= '0;
      tmo_q       <= '0;
      is_run_q    <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      hold_q      <= HOLD_AT_RESET;
      run_pulse_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      lo_q        <= lo_d;
      words_q     <= words_d;
      addr_q      <= addr_d;
      byte_q      <= byte_d;
      buf_q       <= buf_d;
      tmo_q       <= tmo_d;
      is_run_q    <= is_run_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      hold_q      <= hold_d;
      run_pulse_q <= run_pulse_d;
      done_q      <= done_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end
  always_comb begin
    state_d = state_q;
    if (timeout) state_d = S_IDLE;
    else if (in_valid)
      case (state_q)
        S_IDLE:  state_d = in_data == SYNC_BYTE ? S_CMD : S_IDLE;
        S_CMD:   state_d = in_data == 8'h01 ? S_ALO : in_data == 8'h02 ? S_CHK : S_IDLE;
        S_ALO:   state_d = S_AHI;
        S_AHI:   state_d = S_LEN;
        S_LEN:   state_d = S_PAY;
        S_PAY:   state_d = last_byte && words_q == 8'd0 ? S_CHK : S_PAY;
        default: state_d = S_IDLE;
      endcase
  end
  always_comb begin
    sum_d       = sum_q;
    lo_d        = lo_q;
    words_d     = words_q;
    addr_d      = addr_q;
    byte_d      = byte_q;
    buf_d       = buf_q;
    tmo_d       = (state_q == S_IDLE || in_valid || timeout) ? '0 : tmo_q + 1'b1;
    is_run_d    = is_run_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    hold_d      = hold_q;
    run_pulse_d = 1'b0;
    done_d      = 1'b0;
    err_d       = timeout;
    busy_d      = state_d != S_IDLE;
    if (in_valid) begin
      sum_d = state_q == S_IDLE ? 8'd0 : chk_sum;
      case (state_q)
        S_CMD: begin
          is_run_d = in_data == 8'h02;
          hold_d   = in_data == 8'h01 ? 1'b1 : hold_q;
          err_d    = in_data != 8'h01 && in_data != 8'h02;
        end
        S_ALO: lo_d = in_data;
        S_AHI: addr_d = ADDR_W'({in_data, lo_q});
        S_LEN: begin
          words_d = in_data;
          byte_d  = '0;
        end
        S_PAY: begin
          buf_d     = buf_sh;
          byte_d    = last_byte ? '0 : byte_q + 1'b1;
          wr_en_d   = last_byte;
          wr_addr_d = last_byte ? addr_q : wr_addr_q;
          wr_data_d = last_byte ? buf_sh : wr_data_q;
          addr_d    = last_byte ? addr_q + 1'b1 : addr_q;
          words_d   = last_byte ? words_q - 8'd1 : words_q;
        end
        S_CHK: begin
          done_d      = good;
          err_d       = !good;
          run_pulse_d = good && is_run_q;
          hold_d      = good && is_run_q ? 1'b0 : hold_q;
        end
        default: ;
      endcase
    end
  end
  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign cpu_hold    = hold_q;
  assign run_pulse   = run_pulse_q;
  assign frame_done  = done_q;
  assign frame_error = err_q;
  assign busy        = busy_q;
endmodule

// File: tb/tb_uart_frame_loader.sv
// tb_uart_frame_loader: table-driven byte vectors plus hand sequences for timeout and reset abort.
module tb_uart_frame_loader;
  logic        clk = 1'b0, reset_n = 1'b1, in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        wr_en, cpu_hold, run_pulse, frame_done, frame_error, busy;
  logic [15:0] wr_addr, wr_data;
  int errors = 0, checks = 0;
  uart_frame_loader #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .cpu_hold(cpu_hold),
    .run_pulse(run_pulse), .frame_done(frame_done), .frame_error(frame_error), .busy(busy)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic we; logic [15:0] wa; logic [15:0] wd; logic hold; logic run; logic done; logic err; logic busy;
  } out_t;
  typedef struct {logic v; logic [7:0] d; out_t o;} vec_t;
  vec_t tbl[$];
  function automatic out_t O(logic we, logic [15:0] wa, logic [15:0] wd,
                             logic hold, logic run, logic done, logic err, logic bsy);
    return {we, wa, wd, hold, run, done, err, bsy};
  endfunction
  function automatic out_t snap();
    return {wr_en, wr_addr, wr_data, cpu_hold, run_pulse, frame_done, frame_error, busy};
  endfunction
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask
  task automatic drive(input logic v, input logic [7:0] d);
    @(negedge clk);
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    #1;
  endtask
  task automatic add(input logic v, input logic [7:0] d, input out_t o);
    tbl.push_back('{v, d, o});
  endtask
  initial begin
    // single word write to 0x0010, checksum 0x100-0x57
    add(1, 8'hA5, O(0, 16'h0000, 16'h0000, 1, 0, 0, 0, 1));
    add(1, 8'h01, O(0, 16'h0000, 16'h0000, 1, 0, 0, 0, 1));
    add(1, 8'h10, O(0, 16'h0000, 16'h0000, 1, 0, 0, 0, 1));
    add(1, 8'h00, O(0, 16'h0000, 16'h0000, 1, 0, 0, 0, 1));
    add(1, 8'h00, O(0, 16'h0000, 16'h0000, 1, 0, 0, 0, 1));
    add(1, 8'h34, O(0, 16'h0000, 16'h0000, 1, 0, 0, 0, 1));
    add(1, 8'h12, O(1, 16'h0010, 16'h1234, 1, 0, 0, 0, 1));
    add(1, 8'hA9, O(0, 16'h0010, 16'h1234, 1, 0, 1, 0, 0));
    add(0, 8'h00, O(0, 16'h0010, 16'h1234, 1, 0, 0, 0, 0));
    // run
    add(1, 8'hA5, O(0, 16'h0010, 16'h1234, 1, 0, 0, 0, 1));
    add(1, 8'h02, O(0, 16'h0010, 16'h1234, 1, 0, 0, 0, 1));
    add(1, 8'hFE, O(0, 16'h0010, 16'h1234, 0, 1, 1, 0, 0));
    add(0, 8'h00, O(0, 16'h0010, 16'h1234, 0, 0, 0, 0, 0));
    // same write with a bad checksum: write lands, frame errors
    add(1, 8'hA5, O(0, 16'h0010, 16'h1234, 0, 0, 0, 0, 1));
    add(1, 8'h01, O(0, 16'h0010, 16'h1234, 1, 0, 0, 0, 1));
    add(1, 8'h10, O(0, 16'h0010, 16'h1234, 1, 0, 0, 0, 1));
    add(1, 8'h00, O(0, 16'h0010, 16'h1234, 1, 0, 0, 0, 1));
    add(1, 8'h00, O(0, 16'h0010, 16'h1234, 1, 0, 0, 0, 1));
    add(1, 8'h34, O(0, 16'h0010, 16'h1234, 1, 0, 0, 0, 1));
    add(1, 8'h12, O(1, 16'h0010, 16'h1234, 1, 0, 0, 0, 1));
    add(1, 8'h00, O(0, 16'h0010, 16'h1234, 1, 0, 0, 1, 0));
    // bad run keeps hold
    add(1, 8'hA5, O(0, 16'h0010, 16'h1234, 1, 0, 0, 0, 1));
    add(1, 8'h02, O(0, 16'h0010, 16'h1234, 1, 0, 0, 0, 1));
    add(1, 8'h00, O(0, 16'h0010, 16'h1234, 1, 0, 0, 1, 0));
    // stray bytes
    add(1, 8'h00, O(0, 16'h0010, 16'h1234, 1, 0, 0, 0, 0));
    add(1, 8'hFF, O(0, 16'h0010, 16'h1234, 1, 0, 0, 0, 0));
    // address wrap FFFF -> 0000, LEN=1, CHK=0x56
    add(1, 8'hA5, O(0, 16'h0010, 16'h1234, 1, 0, 0, 0, 1));
    add(1, 8'h01, O(0, 16'h0010, 16'h1234, 1, 0, 0, 0, 1));
    add(1, 8'hFF, O(0, 16'h0010, 16'h1234, 1, 0, 0, 0, 1));
    add(1, 8'hFF, O(0, 16'h0010, 16'h1234, 1, 0, 0, 0, 1));
    add(1, 8'h01, O(0, 16'h0010, 16'h1234, 1, 0, 0, 0, 1));
    add(1, 8'h11, O(0, 16'h0010, 16'h1234, 1, 0, 0, 0, 1));
    add(1, 8'h22, O(1, 16'hFFFF, 16'h2211, 1, 0, 0, 0, 1));
    add(1, 8'h33, O(0, 16'hFFFF, 16'h2211, 1, 0, 0, 0, 1));
    add(1, 8'h44, O(1, 16'h0000, 16'h4433, 1, 0, 0, 0, 1));
    add(1, 8'h56, O(0, 16'h0000, 16'h4433, 1, 0, 1, 0, 0));
    // SYNC value as payload data, CHK=0xB2
    add(1, 8'hA5, O(0, 16'h0000, 16'h4433, 1, 0, 0, 0, 1));
    add(1, 8'h01, O(0, 16'h0000, 16'h4433, 1, 0, 0, 0, 1));
    add(1, 8'h03, O(0, 16'h0000, 16'h4433, 1, 0, 0, 0, 1));
    add(1, 8'h00, O(0, 16'h0000, 16'h4433, 1, 0, 0, 0, 1));
    add(1, 8'h00, O(0, 16'h0000, 16'h4433, 1, 0, 0, 0, 1));
    add(1, 8'hA5, O(0, 16'h0000, 16'h4433, 1, 0, 0, 0, 1));
    add(1, 8'hA5, O(1, 16'h0003, 16'hA5A5, 1, 0, 0, 0, 1));
    add(1, 8'hB2, O(0, 16'h0003, 16'hA5A5, 1, 0, 1, 0, 0));
    // unknown command
    add(1, 8'hA5, O(0, 16'h0003, 16'hA5A5, 1, 0, 0, 0, 1));
    add(1, 8'h07, O(0, 16'h0003, 16'hA5A5, 1, 0, 0, 1, 0));
    add(0, 8'h00, O(0, 16'h0003, 16'hA5A5, 1, 0, 0, 0, 0));
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("reset_state", 64'(snap()), 64'(O(0, 16'h0000, 16'h0000, 1, 0, 0, 0, 0)));
    @(negedge clk) reset_n = 1'b1;
    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].d);
      chk($sformatf("vec%0d", i), 64'(snap()), 64'(tbl[i].o));
    end
    // timeout: error on the 15th edge after the last strobe
    drive(1, 8'hA5);
    drive(1, 8'h01);
    for (int k = 1; k <= 16; k++) begin
      drive(0, 8'h00);
      chk($sformatf("timeout_k%0d", k), {62'd0, frame_error, busy}, {62'd0, k == 15, k < 15});
    end
    drive(1, 8'hA5);
    drive(1, 8'h02);
    drive(1, 8'hFE);
    chk("after_timeout_run", {60'd0, run_pulse, frame_done, cpu_hold, busy}, 64'b1100);
    // byte arriving on the timeout edge wins
    drive(1, 8'hA5);
    repeat (14) drive(0, 8'h00);
    chk("pre_edge_no_err", {62'd0, frame_error, busy}, 64'b01);
    drive(1, 8'h02);
    chk("byte_wins", {62'd0, frame_error, busy}, 64'b01);
    drive(1, 8'hFE);
    chk("byte_wins_run", {60'd0, run_pulse, frame_done, frame_error, busy}, 64'b1100);
    // reset mid-payload with a half-filled word
    drive(1, 8'hA5);
    drive(1, 8'h01);
    drive(1, 8'h00);
    drive(1, 8'h00);
    drive(1, 8'h00);
    drive(1, 8'h34);
    #2 reset_n = 1'b0;
    #1 chk("abort_async", 64'(snap()), 64'(O(0, 16'h0000, 16'h0000, 1, 0, 0, 0, 0)));
    @(negedge clk) in_valid = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    drive(1, 8'h12);
    chk("abort_no_write", 64'(snap()), 64'(O(0, 16'h0000, 16'h0000, 1, 0, 0, 0, 0)));
    drive(1, 8'hA9);
    chk("abort_chk_ignored", 64'(snap()), 64'(O(0, 16'h0000, 16'h0000, 1, 0, 0, 0, 0)));
    drive(1, 8'hA5);
    drive(1, 8'h02);
    drive(1, 8'hFE);
    chk("abort_then_run", 64'(snap()), 64'(O(0, 16'h0000, 16'h0000, 0, 1, 1, 0, 0)));
    drive(0, 8'h00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
